// File: rtl/i3c_bus_arbiter_if.sv
// Request/grant bundle between the I3C bus arbiter and the secondary masters.
// Ports: req/ibi_req/owner_release/bus_idle in; grant/ibi_grant/primary_owns/owner_id/timeout_err out.
interface i3c_bus_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ibi_req;
    logic [NUM_REQ-1:0] owner_release;
    logic               bus_idle;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ibi_grant;
    logic               primary_owns;
    logic [IW-1:0]      owner_id;
    logic               timeout_err;

    modport master (
        output req, ibi_req, owner_release, bus_idle,
        input  grant, ibi_grant, primary_owns, owner_id, timeout_err
    );

    modport slave (
        input  req, ibi_req, owner_release, bus_idle,
        output grant, ibi_grant, primary_owns, owner_id, timeout_err
    );
endinterface

// File: rtl/i3c_bus_arbiter.sv
// I3C mastership/IBI arbiter: picks one secondary master, waits for bus-free, grants, reclaims.
// Ports: clk, reset_n (sync, active-low), bus (slave side: requests in, grants/status out).
module i3c_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CYCLES = 8,
    parameter int TIMEOUT     = 255
) (
    input logic               clk,
    input logic               reset_n,
    i3c_bus_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int HW = $clog2(TIMEOUT + 1);
    localparam int CW = $clog2(IDLE_CYCLES + 1);

    typedef enum logic [1:0] {
        PRIMARY,
        WAIT_IDLE,
        GRANT,
        RECLAIM
    } state_t;

    state_t             state;
    logic [IW-1:0]      win;
    logic               win_ibi;
    logic [CW-1:0]      idle_cnt;
    logic [HW-1:0]      hold_cnt;
    logic [IW-1:0]      rr_ibi;
    logic [IW-1:0]      rr_mst;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] ibi_grant_q;
    logic               primary_q;
    logic [IW-1:0]      owner_q;
    logic               timeout_q;

    // Returns {hit, index}: first set bit at or above p, wrapping.
    // The loop runs downward so the smallest offset is written last.
    function automatic logic [IW:0] rr_pick(
        input logic [NUM_REQ-1:0] v,
        input logic [IW-1:0]      p
    );
        logic [IW:0] r;
        int          j;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = (int'(p) + i) % NUM_REQ;
            if (v[j[IW-1:0]]) r = {1'b1, j[IW-1:0]};
        end
        return r;
    endfunction

    logic [IW:0]        ibi_pick;
    logic [IW:0]        mst_pick;
    logic               win_req;
    logic               win_rel;
    logic [NUM_REQ-1:0] win_oh;
    logic [IW-1:0]      win_nxt;

    assign ibi_pick = rr_pick(bus.ibi_req, rr_ibi);
    assign mst_pick = rr_pick(bus.req, rr_mst);
    assign win_req  = win_ibi ? bus.ibi_req[win] : bus.req[win];
    assign win_rel  = bus.owner_release[win];
    assign win_oh   = NUM_REQ'(1) << win;
    assign win_nxt  = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= PRIMARY;
            win         <= '0;
            win_ibi     <= 1'b0;
            idle_cnt    <= '0;
            hold_cnt    <= '0;
            rr_ibi      <= '0;
            rr_mst      <= '0;
            grant_q     <= '0;
            ibi_grant_q <= '0;
            primary_q   <= 1'b1;
            owner_q     <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state)
                PRIMARY: begin
                    // IBI class strictly beats mastership class
                    if (ibi_pick[IW]) begin
                        win      <= ibi_pick[IW-1:0];
                        owner_q  <= ibi_pick[IW-1:0];
                        win_ibi  <= 1'b1;
                        idle_cnt <= '0;
                        state    <= WAIT_IDLE;
                    end else if (mst_pick[IW]) begin
                        win      <= mst_pick[IW-1:0];
                        owner_q  <= mst_pick[IW-1:0];
                        win_ibi  <= 1'b0;
                        idle_cnt <= '0;
                        state    <= WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    // Withdrawal wins over a same-cycle grant
                    if (!win_req) begin
                        state <= PRIMARY;
                    end else if (!bus.bus_idle) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == CW'(IDLE_CYCLES - 1)) begin
                        state     <= GRANT;
                        hold_cnt  <= '0;
                        primary_q <= 1'b0;
                        if (win_ibi) ibi_grant_q <= win_oh;
                        else         grant_q     <= win_oh;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                GRANT: begin
                    if (win_rel || !win_req) begin
                        state       <= RECLAIM;
                        grant_q     <= '0;
                        ibi_grant_q <= '0;
                    end else if (hold_cnt == HW'(TIMEOUT - 1)) begin
                        state       <= RECLAIM;
                        grant_q     <= '0;
                        ibi_grant_q <= '0;
                        timeout_q   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RECLAIM: begin
                    if (win_ibi) rr_ibi <= win_nxt;
                    else         rr_mst <= win_nxt;
                    primary_q <= 1'b1;
                    state     <= PRIMARY;
                end
                default: state <= PRIMARY;
            endcase
        end
    end

    assign bus.grant        = grant_q;
    assign bus.ibi_grant    = ibi_grant_q;
    assign bus.primary_owns = primary_q;
    assign bus.owner_id     = owner_q;
    assign bus.timeout_err  = timeout_q;
endmodule

// File: doc/i3c_bus_arbiter.md
Name: i3c_bus_arbiter

Overview:
Mastership and IBI scheduler for the shared I3C SDA/SCL bus. The primary master is the default bus owner. Secondary masters raise mastership requests or in-band-interrupt (IBI) requests, and the arbiter selects one winner, waits for bus-free time, and hands over ownership. It reclaims the bus for the primary master on release, on request withdrawal, or on hold timeout. It sits beside the primary master in the I3C system and drives the grant inputs of each secondary master.

Parameters:
NUM_REQ, 4, number of secondary-master requesters (>=2).
IDLE_CYCLES, 8, consecutive bus_idle cycles required before a grant (>=1).
TIMEOUT, 255, maximum cycles a grant may be held (>=1).

Ports:
clk  input  1  system clock.
reset_n  input  1  reset. One clock; reset is synchronous and active-low.
req  input  NUM_REQ  level mastership request per secondary master.
ibi_req  input  NUM_REQ  level IBI request per secondary master.
release  input  NUM_REQ  1-cycle pulse: owner done with bus.
bus_idle  input  1  from bus monitor: SDA and SCL both high.
grant  output  NUM_REQ  one-hot mastership grant.
ibi_grant  output  NUM_REQ  one-hot IBI grant (owner drives IBI header).
primary_owns  output  1  primary master owns bus.
owner_id  output  $clog2(NUM_REQ)  index of current or last winner.
timeout_err  output  1  1-cycle pulse on forced reclaim.

Behaviour:
- All outputs are registered.
- Reset values: state=PRIMARY, grant=0, ibi_grant=0, primary_owns=1, owner_id=0, timeout_err=0, both round-robin pointers=0, idle_cnt=0, hold_cnt=0.
- Reset mid-operation: values above appear at the first edge where reset_n=0 is sampled, in any state.
- Arbitration classes: the IBI class strictly beats the mastership class.
  - Within a class, round-robin starts at that class's pointer (rr_ibi, rr_mst) and searches upward with wrap.
- State PRIMARY:
  - If ibi_req or req is nonzero: latch winner index and class, load owner_id, clear idle_cnt, go WAIT_IDLE.
  - Otherwise stay.
- State WAIT_IDLE:
  - bus_idle=0: idle_cnt clears.
  - bus_idle=1 and idle_cnt==IDLE_CYCLES-1: go GRANT.
  - bus_idle=1 otherwise: idle_cnt increments.
  - Winner's request bit (in its class) deasserts: return to PRIMARY, no grant, pointer unchanged. This takes priority over the GRANT transition.
- State GRANT:
  - Outputs: the winner's bit is set in grant or ibi_grant; primary_owns=0; hold_cnt starts at 0 and increments each cycle.
  - release[winner] or winner's request deasserting: go RECLAIM.
  - Else if hold_cnt==TIMEOUT-1: go RECLAIM with timeout_err=1.
  - release from a non-owner is ignored.
  - Release and timeout in the same cycle: release wins, timeout_err stays 0.
- State RECLAIM (exactly 1 cycle, turnaround gap):
  - Outputs: grant=0, ibi_grant=0, primary_owns=0, timeout_err high only if entered by timeout.
  - Winning class pointer becomes (winner+1) mod NUM_REQ.
  - Next state is PRIMARY, where primary_owns=1. Requests are evaluated again from PRIMARY.
- Latency:
  - Request first sampled in PRIMARY at cycle 0 with bus_idle held high: grant visible at cycle IDLE_CYCLES+1.
  - Grant high for at most TIMEOUT cycles.
  - From release sampled to primary_owns=1: 2 cycles.
- Invariants:
  - At most one bit set across grant|ibi_grant.
  - primary_owns=1 implies no grant bit set.
- Width rules: hold_cnt is $clog2(TIMEOUT+1) bits and idle_cnt is $clog2(IDLE_CYCLES+1) bits. Neither counter ever wraps.

Test Plan:
- req=4'b0010, bus_idle=1 → grant=4'b0010 and primary_owns=0 at cycle 9. release[1] pulse → grant=0 next cycle, primary_owns=1 the cycle after.
- req=4'b1111 held, each owner releases 3 cycles after grant → grant sequence 0001, 0010, 0100, 1000, 0001.
- ibi_req=4'b0100 and req=4'b0001 raised in the same cycle → ibi_grant=4'b0100 first. After release, grant=4'b0001.
- Single req, bus_idle dropped for 1 cycle at WAIT_IDLE cycle 5 → grant delayed until 8 consecutive idle cycles after bus_idle returns.
- Owner never releases → grant high exactly 255 cycles, timeout_err=1 for 1 cycle, then primary_owns=1 and rr_mst advanced.
- reset_n=0 during GRANT → all outputs at reset values after the next edge. Separately, release[3] while owner is 1 → no effect.
